// File: rtl/db_arbiter.sv
// db_arbiter: two-channel data-break arbiter.
// Picks one of two device channels round-robin, presents its address, data
// and direction to the CPU as a data break, follows the CPU major state
// through DB0..DB2, captures read data, pulses done, then holds off for
// HOLDOFF cycles so the CPU is guaranteed to make progress between breaks.
module db_arbiter #(
  parameter int unsigned HOLDOFF = 2,
  // CPU major-state codes, kept in step with the shared CPU parameter set
  parameter logic [4:0]  ST_DB0  = 5'd20,
  parameter logic [4:0]  ST_DB2  = 5'd22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic        req0,
  input  logic        req1,
  input  logic [0:14] addr0,
  input  logic [0:14] addr1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [0:11] wdata0,
  input  logic [0:11] wdata1,
  input  logic [0:11] mem2disk,
  output logic        data_break,
  output logic [0:14] dmaAddr,
  output logic [0:11] disk2mem,
  output logic        to_disk,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [0:11] rdata,
  output logic        busy
);

  // Counter is at least one bit wide so HOLDOFF = 0 still elaborates cleanly
  localparam int unsigned CW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLDOFF);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    BREAK   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } fsm_t;

  fsm_t          fsm_r;
  logic [CW-1:0] cnt_r;   // holdoff counter
  logic          last_r;  // channel served most recently (0 or 1)
  logic          pick1_s; // 1 when channel 1 wins the current arbitration

  // Round-robin winner: on contention the channel not served last wins
  always_comb begin
    pick1_s = 1'b0;
    if (req0 && req1) begin
      pick1_s = ~last_r;
    end else if (req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
  end

  // Break sequencer; all outputs except busy are registered here.
  // done/rdata are registered on the DB2 edge so that they are visible
  // during the CAPTURE cycle, i.e. the cycle right after DB2.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r      <= IDLE;
      cnt_r      <= CNT_ZERO;
      last_r     <= 1'b1;
      data_break <= 1'b0;
      dmaAddr    <= 15'o00000;
      disk2mem   <= 12'o0000;
      to_disk    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= 12'o0000;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if ((req0 || req1) && (cnt_r == CNT_ZERO)) begin
            fsm_r      <= ARM;
            data_break <= 1'b1;
            gnt0       <= ~pick1_s;
            gnt1       <= pick1_s;
            if (pick1_s) begin
              dmaAddr  <= addr1;
              disk2mem <= wdata1;
              to_disk  <= ~wr1;
            end else begin
              dmaAddr  <= addr0;
              disk2mem <= wdata0;
              to_disk  <= ~wr0;
            end
          end
        end
        ARM: begin
          // Waits for the CPU as long as it takes; no timeout by design
          if (state == ST_DB0) begin
            fsm_r      <= BREAK;
            data_break <= 1'b0;
          end
        end
        BREAK: begin
          if (state == ST_DB2) begin
            fsm_r  <= CAPTURE;
            done0  <= gnt0;
            done1  <= gnt1;
            last_r <= gnt1;
            if (to_disk) begin
              rdata <= mem2disk;
            end
          end
        end
        CAPTURE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          cnt_r <= CNT_LOAD;
          if (HOLDOFF == 0) begin
            fsm_r <= IDLE;
          end else begin
            fsm_r <= HOLD;
          end
        end
        HOLD: begin
          // Exactly HOLDOFF cycles are spent here
          if (cnt_r <= CNT_ONE) begin
            cnt_r <= CNT_ZERO;
            fsm_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          fsm_r      <= IDLE;
          cnt_r      <= CNT_ZERO;
          data_break <= 1'b0;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (fsm_r != IDLE);

endmodule

// File: doc/db_arbiter.md
DB_ARBITER -- requirements
Module: db_arbiter

Interface
REQ-001 SHALL have parameter HOLDOFF, default 2: minimum clk cycles in IDLE after a completed break before the next break may be armed (CPU progress guarantee).
REQ-002 SHALL have ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- state  in  5  CPU major state; codes F0, DB0 and DB2 come from the shared parameters file.
- req0, req1  in  1 each  data-break request per channel; held high until that channel's done pulse.
- addr0, addr1  in  15 [0:14]  target field+address per channel.
- wr0, wr1  in  1 each  1 = write memory (device to core), 0 = read memory.
- wdata0, wdata1  in  12 [0:11]  write data per channel.
- mem2disk  in  12 [0:11]  read data returned by the memory-address block.
- data_break  out  1  break request to the CPU/memory-address block.
- dmaAddr  out  15 [0:14]  break address.
- disk2mem  out  12 [0:11]  break write data.
- to_disk  out  1  1 = read cycle (memory to device).
- gnt0, gnt1  out  1 each  channel owns the current break.
- done0, done1  out  1 each  one-cycle completion pulse.
- rdata  out  12 [0:11]  captured read word, valid with done.
- busy  out  1  FSM not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ARM, BREAK, CAPTURE, HOLD.
REQ-004 IDLE: if any req is high and the holdoff counter is 0, SHALL select a winner, register its addr/wdata/direction into dmaAddr/disk2mem/to_disk (to_disk = ~wr), assert its gnt, and go to ARM next cycle.
REQ-005 Arbitration SHALL be round-robin: with both requests high, the channel not served last wins; a single request wins regardless; last-served resets to channel 1, so channel 0 wins first after reset.
REQ-006 ARM: data_break SHALL be 1; when state == DB0, SHALL go to BREAK with data_break deasserted in that next cycle.
REQ-007 ARM SHALL persist indefinitely while state != DB0; no timeout.
REQ-008 BREAK: when state == DB2, SHALL go to CAPTURE.
REQ-009 CAPTURE (the cycle after DB2): SHALL load rdata <= mem2disk when to_disk = 1, leave rdata unchanged when to_disk = 0, pulse done of the granted channel for exactly this cycle, update last-served, load the holdoff counter with HOLDOFF, and go to HOLD.
REQ-010 HOLD: gnt SHALL drop, and the counter SHALL decrement each cycle; the FSM SHALL return to IDLE when the counter is 0, or immediately if HOLDOFF = 0.
REQ-011 dmaAddr, disk2mem and to_disk SHALL stay stable from ARM entry through CAPTURE; changes on addr/wdata/wr after grant SHALL be ignored.
REQ-012 gnt0 and gnt1 SHALL never both be 1; gnt SHALL be high for ARM, BREAK and CAPTURE.
REQ-013 Request dropped after grant: the break SHALL still complete, and done SHALL still pulse.
REQ-014 Request re-asserted in the done cycle SHALL be eligible only after HOLD expires, and round-robin SHALL then favour the other channel if it is pending.
REQ-015 Latency from req (IDLE, counter 0) to data_break SHALL be exactly 1 cycle.
REQ-016 busy SHALL equal (FSM != IDLE).

Reset
REQ-017 On reset: FSM = IDLE; data_break, gnt0, gnt1, done0, done1, to_disk = 0; dmaAddr = 15'o00000; disk2mem = rdata = 12'o0000; holdoff counter = 0; last-served = 1. Reset SHALL win over every other event, including mid-break, with no done pulse.

Verification
REQ-018 Bench SHALL check: req0, wr0 = 1, addr0 = 15'o12345, wdata0 = 12'o7070, state F0 -> F0 -> DB0 -> DB1 -> DB2 -> data_break 1 cycle after req; dmaAddr = 15'o12345, disk2mem = 12'o7070, to_disk = 0; done0 pulses the cycle after DB2.
REQ-019 Bench SHALL check: req1 read of 15'o00200 with mem2disk = 12'o4321 after DB2 -> rdata = 12'o4321 and done1 in the same cycle.
REQ-020 Bench SHALL check: req0 and req1 raised together and held -> channel 0 served first, then channel 1 after exactly HOLDOFF idle cycles; gnt signals mutually exclusive throughout.
REQ-021 Bench SHALL check: state never reaches DB0 for 1000 cycles -> data_break stays 1, gnt held, no done.
REQ-022 Bench SHALL check: reset asserted while in BREAK -> next cycle all outputs at reset values, no done pulse; req0 still high -> new grant for channel 0 one cycle after reset deasserts.
REQ-023 Bench SHALL check: addr0 changed while in ARM -> dmaAddr keeps the originally granted value.
